// File: rtl/card_pair_checker_pkg.sv
// card_pair_checker_pkg: card word layout, colours, FSM states and card helpers
package card_pair_checker_pkg;

    localparam logic [11:0] RED    = 12'hF00;
    localparam logic [11:0] GREEN  = 12'h0F0;
    localparam logic [11:0] BLUE   = 12'h00F;
    localparam logic [11:0] YELLOW = 12'hFF0;
    localparam logic [11:0] PURPLE = 12'hF0F;
    localparam logic [11:0] MINT   = 12'h0FF;

    localparam int CARD_ACTIVE    = 0;
    localparam int CARD_DISC      = 1;
    localparam int CARD_COLOR_LSB = 2;
    localparam int CARD_COLOR_MSB = 13;

    localparam logic [3:0] CARD_FIRST = 4'd1;
    localparam logic [3:0] CARD_LAST  = 4'd12;

    typedef enum logic [3:0] {
        S_FIRST,
        S_RD1,
        S_CHK1,
        S_SECOND,
        S_RD2,
        S_CHK2,
        S_MATCH_B,
        S_MATCH_A,
        S_SHOW,
        S_HIDE_A,
        S_HIDE_B,
        S_WON
    } state_e;

    function automatic logic addr_legal(input logic [3:0] a);
        return (a >= CARD_FIRST) && (a <= CARD_LAST);
    endfunction

    function automatic logic card_free(input logic [13:0] w);
        return w[CARD_ACTIVE] & ~w[CARD_DISC];
    endfunction

endpackage

// File: rtl/card_pair_checker_show_timer.sv
// show_timer: o_done is high in the SHOW_CYCLES-th cycle after a start
module show_timer #(
    parameter int SHOW_CYCLES = 40_000_000,
    parameter int SHOW_W      = 26
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_clear,
    output logic o_done
);

    logic [SHOW_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear)
            r_cnt <= '0;
        else if (i_start)
            r_cnt <= SHOW_W'(SHOW_CYCLES - 1);
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/card_pair_checker.sv
// card_pair_checker: reveals picked cards, retires matched pairs, re-covers mismatches
module card_pair_checker
    import card_pair_checker_pkg::*;
#(
    parameter int SHOW_CYCLES = 40_000_000,
    parameter int SHOW_W      = 26,
    parameter int NUM_PAIRS   = 6
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_pick_valid,
    input  logic [3:0]  i_pick_addr,
    output logic        o_pick_ready,
    output logic        o_pick_reject,
    output logic [3:0]  o_rd_addr,
    input  logic [13:0] i_rd_data,
    output logic        o_wr_en,
    output logic [3:0]  o_wr_addr,
    output logic [13:0] o_wr_data,
    output logic        o_match,
    output logic        o_mismatch,
    output logic [2:0]  o_match_count,
    output logic        o_game_won
);

    state_e      r_state, w_state;
    logic [3:0]  r_rd_addr, w_rd_addr, r_wr_addr, w_wr_addr;
    logic [3:0]  r_addr_a, w_addr_a, r_addr_b, w_addr_b;
    logic [11:0] r_col_a, w_col_a, r_col_b, w_col_b;
    logic [13:0] r_wr_data, w_wr_data;
    logic [2:0]  r_count, w_count;
    logic        r_wr_en, w_wr_en, r_reject, w_reject, r_match, w_match;
    logic        r_mismatch, w_mismatch, r_won, w_won;
    logic        w_pick, w_timer_start, w_timer_clear, w_timer_done;
    logic [11:0] w_rd_col;

    assign w_rd_col     = i_rd_data[CARD_COLOR_MSB:CARD_COLOR_LSB];
    assign o_pick_ready = i_enable & (r_state == S_FIRST || r_state == S_SECOND);
    assign w_pick       = i_pick_valid & o_pick_ready;

    show_timer #(.SHOW_CYCLES(SHOW_CYCLES), .SHOW_W(SHOW_W)) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_timer_start),
        .i_clear (w_timer_clear),
        .o_done  (w_timer_done)
    );

    // Outputs are decided on the transition and registered, so each write is
    // visible during the state that owns it.
    always_comb begin
        w_state       = r_state;
        w_rd_addr     = r_rd_addr;
        w_wr_en       = 1'b0;
        w_wr_addr     = r_wr_addr;
        w_wr_data     = r_wr_data;
        w_reject      = 1'b0;
        w_match       = 1'b0;
        w_mismatch    = 1'b0;
        w_count       = r_count;
        w_won         = r_won;
        w_addr_a      = r_addr_a;
        w_col_a       = r_col_a;
        w_addr_b      = r_addr_b;
        w_col_b       = r_col_b;
        w_timer_start = 1'b0;
        w_timer_clear = 1'b0;
        case (r_state)
            S_FIRST, S_SECOND: begin
                if (w_pick && addr_legal(i_pick_addr)) begin
                    w_state   = (r_state == S_FIRST) ? S_RD1 : S_RD2;
                    w_rd_addr = i_pick_addr;
                end else if (w_pick) begin
                    w_reject = 1'b1;
                end
            end
            S_RD1: w_state = S_CHK1;
            S_RD2: w_state = S_CHK2;
            S_CHK1: begin
                if (card_free(i_rd_data)) begin
                    w_addr_a  = r_rd_addr;
                    w_col_a   = w_rd_col;
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_rd_addr;
                    w_wr_data = {w_rd_col, 2'b11};
                    w_state   = S_SECOND;
                end else begin
                    w_reject = 1'b1;
                    w_state  = S_FIRST;
                end
            end
            S_CHK2: begin
                if (card_free(i_rd_data)) begin
                    w_addr_b  = r_rd_addr;
                    w_col_b   = w_rd_col;
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_rd_addr;
                    if (w_rd_col == r_col_a) begin
                        w_wr_data = {w_rd_col, 2'b10};
                        w_match   = 1'b1;
                        w_count   = (r_count == 3'(NUM_PAIRS)) ? r_count : r_count + 3'd1;
                        w_state   = S_MATCH_B;
                    end else begin
                        w_wr_data     = {w_rd_col, 2'b11};
                        w_mismatch    = 1'b1;
                        w_timer_start = 1'b1;
                        w_state       = S_SHOW;
                    end
                end else begin
                    w_reject = 1'b1;
                    w_state  = S_SECOND;
                end
            end
            S_MATCH_B: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_addr_a;
                w_wr_data = {r_col_a, 2'b10};
                w_state   = S_MATCH_A;
            end
            S_MATCH_A: begin
                w_won   = (r_count == 3'(NUM_PAIRS));
                w_state = (r_count == 3'(NUM_PAIRS)) ? S_WON : S_FIRST;
            end
            S_SHOW: begin
                if (w_timer_done) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_addr_a;
                    w_wr_data = {r_col_a, 2'b01};
                    w_state   = S_HIDE_A;
                end
            end
            S_HIDE_A: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_addr_b;
                w_wr_data = {r_col_b, 2'b01};
                w_state   = S_HIDE_B;
            end
            S_HIDE_B: w_state = S_FIRST;
            S_WON:    w_state = S_WON;
            default:  w_state = S_FIRST;
        endcase
        if (!i_enable && r_state != S_WON) begin
            w_state       = S_FIRST;
            w_wr_en       = 1'b0;
            w_reject      = 1'b0;
            w_match       = 1'b0;
            w_mismatch    = 1'b0;
            w_count       = r_count;
            w_timer_start = 1'b0;
            w_timer_clear = 1'b1;
            w_addr_a      = '0;
            w_col_a       = '0;
            w_addr_b      = '0;
            w_col_b       = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_FIRST;
            r_rd_addr  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_reject   <= 1'b0;
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
            r_count    <= '0;
            r_won      <= 1'b0;
            r_addr_a   <= '0;
            r_col_a    <= '0;
            r_addr_b   <= '0;
            r_col_b    <= '0;
        end else begin
            r_state    <= w_state;
            r_rd_addr  <= w_rd_addr;
            r_wr_en    <= w_wr_en;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= w_wr_data;
            r_reject   <= w_reject;
            r_match    <= w_match;
            r_mismatch <= w_mismatch;
            r_count    <= w_count;
            r_won      <= w_won;
            r_addr_a   <= w_addr_a;
            r_col_a    <= w_col_a;
            r_addr_b   <= w_addr_b;
            r_col_b    <= w_col_b;
        end
    end

    assign o_rd_addr     = r_rd_addr;
    assign o_wr_en       = r_wr_en;
    assign o_wr_addr     = r_wr_addr;
    assign o_wr_data     = r_wr_data;
    assign o_pick_reject = r_reject;
    assign o_match       = r_match;
    assign o_mismatch    = r_mismatch;
    assign o_match_count = r_count;
    assign o_game_won    = r_won;

endmodule

// File: tb/tb_card_pair_checker.sv
// tb_card_pair_checker: directed picks against a regfile model, writes checked by a scoreboard
module tb_card_pair_checker;
    import card_pair_checker_pkg::*;

    typedef struct packed {
        logic [3:0]  addr;
        logic [13:0] data;
        logic        m;
        logic        mm;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        pick_valid = 1'b0;
    logic [3:0]  pick_addr = '0;
    logic        fill = 1'b0;
    logic        pick_ready, pick_reject, wr_en, match, mismatch, game_won;
    logic [3:0]  rd_addr, wr_addr;
    logic [13:0] rd_data, wr_data;
    logic [2:0]  match_count;
    logic [13:0] mem [0:15];
    logic [11:0] layout [0:15] = '{12'h0, RED, BLUE, GREEN, YELLOW, PURPLE, MINT,
                                   BLUE, GREEN, YELLOW, RED, PURPLE, MINT, 12'h0, 12'h0, 12'h0};
    wr_t         q[$];
    int          wr_cyc[$];
    int          cyc = 0, total = 0, bad = 0, rej_cnt = 0, match_cnt = 0;
    logic [3:0]  ra;

    always #5 clk = ~clk;

    card_pair_checker #(.SHOW_CYCLES(8), .SHOW_W(4), .NUM_PAIRS(6)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (enable),
        .i_pick_valid  (pick_valid),
        .i_pick_addr   (pick_addr),
        .o_pick_ready  (pick_ready),
        .o_pick_reject (pick_reject),
        .o_rd_addr     (rd_addr),
        .i_rd_data     (rd_data),
        .o_wr_en       (wr_en),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_match       (match),
        .o_mismatch    (mismatch),
        .o_match_count (match_count),
        .o_game_won    (game_won)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fill) begin
            for (int i = 0; i < 16; i++)
                mem[i] <= (i >= 1 && i <= 12) ? {layout[i], 2'b01} : 14'h0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic fail(input string n);
        total++;
        bad++;
        $display("FAIL %s", n);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (wr_en) begin
                wr_cyc.push_back(cyc);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", wr_addr, wr_data);
                end else begin
                    e = q.pop_front();
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data", wr_data, e.data);
                    chk("wr_match", match, e.m);
                    chk("wr_mismatch", mismatch, e.mm);
                end
            end else if (match || mismatch) begin
                fail("stray_match_pulse");
            end
            if (pick_reject) rej_cnt++;
            if (match) match_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pick(input logic [3:0] a);
        int n = 0;
        @(negedge clk);
        while (!pick_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail("pick_ready_timeout");
        pick_valid = 1'b1;
        pick_addr  = a;
        @(posedge clk);
        #1 pick_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    task automatic pair(input logic [3:0] a, input logic [3:0] b, input logic [11:0] c);
        q.push_back('{a, {c, 2'b11}, 1'b0, 1'b0});
        q.push_back('{b, {c, 2'b10}, 1'b1, 1'b0});
        q.push_back('{a, {c, 2'b10}, 1'b0, 1'b0});
        pick(a);
        pick(b);
        drain();
    endtask

    task automatic restart();
        rst_n  = 1'b0;
        enable = 1'b0;
        tick(2);
        fill = 1'b1;
        @(posedge clk);
        #1 fill = 1'b0;
        rst_n = 1'b1;
        q.delete();
        wr_cyc.delete();
        enable = 1'b1;
        tick(1);
    endtask

    initial begin
        tick(3);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_match_count", match_count, 0);
        chk("rst_game_won", game_won, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_pick_reject", pick_reject, 0);
        chk("rst_pick_ready", pick_ready, 0);
        restart();
        chk("ready_in_first", pick_ready, 1);

        q.push_back('{4'd1, {RED, 2'b11}, 1'b0, 1'b0});
        q.push_back('{4'd2, {BLUE, 2'b11}, 1'b0, 1'b1});
        q.push_back('{4'd1, {RED, 2'b01}, 1'b0, 1'b0});
        q.push_back('{4'd2, {BLUE, 2'b01}, 1'b0, 1'b0});
        pick(1);
        pick(2);
        drain();
        chk("mm_write_count", wr_cyc.size(), 4);
        if (wr_cyc.size() == 4) begin
            chk("show_gap", wr_cyc[2] - wr_cyc[1], 8);
            chk("hide_gap", wr_cyc[3] - wr_cyc[2], 1);
        end
        tick(2);
        chk("mm_count", match_count, 0);
        chk("mm_back_first", dut.r_state, S_FIRST);

        pair(1, 10, RED);
        chk("match_count_1", match_count, 1);
        chk("match_pulses_1", match_cnt, 1);

        ra = rd_addr;
        pick(0);
        pick(13);
        tick(3);
        chk("illegal_rejects", rej_cnt, 2);
        chk("illegal_rd_hold", rd_addr, ra);

        q.push_back('{4'd3, {GREEN, 2'b11}, 1'b0, 1'b0});
        pick(3);
        pick(3);
        tick(4);
        chk("repick_reject", rej_cnt, 3);
        chk("repick_state", dut.r_state, S_SECOND);
        q.push_back('{4'd8, {GREEN, 2'b10}, 1'b1, 1'b0});
        q.push_back('{4'd3, {GREEN, 2'b10}, 1'b0, 1'b0});
        pick(8);
        drain();
        chk("match_count_2", match_count, 2);

        pair(2, 7, BLUE);
        pair(4, 9, YELLOW);
        pair(5, 11, PURPLE);
        pair(6, 12, MINT);
        tick(2);
        chk("won_count", match_count, 6);
        chk("won_flag", game_won, 1);
        chk("won_ready", pick_ready, 0);
        chk("won_state", dut.r_state, S_WON);
        ra = rd_addr;
        pick_valid = 1'b1;
        pick_addr  = 4'd1;
        tick(5);
        pick_valid = 1'b0;
        enable = 1'b0;
        tick(2);
        chk("won_rd_hold", rd_addr, ra);
        chk("won_sticky", game_won, 1);
        chk("won_no_reject", rej_cnt, 3);

        restart();
        q.push_back('{4'd1, {RED, 2'b11}, 1'b0, 1'b0});
        q.push_back('{4'd2, {BLUE, 2'b11}, 1'b0, 1'b1});
        pick(1);
        pick(2);
        drain();
        chk("in_show", dut.r_state, S_SHOW);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("en_drop_state", dut.r_state, S_FIRST);
        chk("en_drop_wr_en", wr_en, 0);
        tick(15);
        enable = 1'b1;
        tick(2);
        chk("en_drop_idle", dut.r_state, S_FIRST);

        restart();
        q.push_back('{4'd1, {RED, 2'b11}, 1'b0, 1'b0});
        q.push_back('{4'd10, {RED, 2'b10}, 1'b1, 1'b0});
        pick(1);
        pick(10);
        begin
            int n = 0;
            while (!(wr_en && match) && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) fail("match_b_timeout");
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_match", match, 0);
        chk("midrst_count", match_count, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_rd_addr", rd_addr, 0);
        q.delete();
        rst_n = 1'b1;
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
